// File: rtl/meter_pkg.sv
// ---------------------------------------------------------------------------
// meter_pkg
// Shared constants and helpers for the parking-meter timer.
//   - add amounts selected by add_sel (60/120/180/300 s)
//   - load presets selected by load_sel (15/185 s)
//   - default saturation ceiling and low-time blink threshold
//   - state encoding for the sequential binary-to-BCD converter
// ---------------------------------------------------------------------------
package meter_pkg;

    localparam logic [13:0] ADD_AMT_60  = 14'd60;
    localparam logic [13:0] ADD_AMT_120 = 14'd120;
    localparam logic [13:0] ADD_AMT_180 = 14'd180;
    localparam logic [13:0] ADD_AMT_300 = 14'd300;

    localparam logic [13:0] LOAD_SHORT = 14'd15;
    localparam logic [13:0] LOAD_LONG  = 14'd185;

    localparam int MAX_T_DEF = 9999;
    localparam int LOW_T_DEF = 200;

    // 14 double-dabble iterations, counted 0..13
    localparam logic [3:0] BCD_LAST_ITER = 4'd13;

    typedef enum logic [1:0] {
        ADD_SEL_60  = 2'd0,
        ADD_SEL_120 = 2'd1,
        ADD_SEL_180 = 2'd2,
        ADD_SEL_300 = 2'd3
    } add_sel_e;

    typedef enum logic {
        CONV_IDLE = 1'b0,
        CONV_BUSY = 1'b1
    } conv_state_e;

    // Map the add selector onto the number of seconds it buys
    function automatic logic [13:0] add_amount(input add_sel_e sel);
        logic [13:0] amt;
        amt = ADD_AMT_60;
        case (sel)
            ADD_SEL_60:  amt = ADD_AMT_60;
            ADD_SEL_120: amt = ADD_AMT_120;
            ADD_SEL_180: amt = ADD_AMT_180;
            ADD_SEL_300: amt = ADD_AMT_300;
        endcase
        return amt;
    endfunction

    // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift
    function automatic logic [15:0] bcd_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int d = 0; d < 4; d++) begin
            if (v[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = v[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/meter_timer_if.sv
// ---------------------------------------------------------------------------
// meter_timer_if
// Request bus from the debounced button/switch front end to the timer.
//   add_valid  : one-cycle pulse, add the time chosen by add_sel
//   add_sel    : 0=+60, 1=+120, 2=+180, 3=+300 seconds
//   load_valid : one-cycle pulse, overwrite the time chosen by load_sel
//   load_sel   : 0=load 15, 1=load 185
// master = front end (drives), slave = meter_timer (consumes)
// ---------------------------------------------------------------------------
interface meter_timer_if;

    logic       add_valid;
    logic [1:0] add_sel;
    logic       load_valid;
    logic       load_sel;

    modport master (
        output add_valid,
        output add_sel,
        output load_valid,
        output load_sel
    );

    modport slave (
        input add_valid,
        input add_sel,
        input load_valid,
        input load_sel
    );

endinterface

// File: rtl/meter_timer_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, one iteration per clock.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load value and (re)start; aborts a conversion in flight
//   value    : 14-bit binary input, sampled on start
//   bcd      : four BCD digits of the last completed conversion
//   done     : one-cycle pulse when bcd has just been updated
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import meter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] value,
    output logic [15:0] bcd,
    output logic        done
);

    conv_state_e state;
    conv_state_e state_next;

    logic [13:0] bin_sr;
    logic [15:0] acc;
    logic [3:0]  iter;

    logic        shift_en;
    logic        finish;
    logic [15:0] acc_adj;
    logic [15:0] acc_shift;
    logic [13:0] bin_shift;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CONV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a start always wins, even mid-conversion
    always_comb begin
        state_next = state;
        case (state)
            CONV_IDLE: if (start) state_next = CONV_BUSY;
            CONV_BUSY: begin
                if (start) begin
                    state_next = CONV_BUSY;
                end else if (finish) begin
                    state_next = CONV_IDLE;
                end
            end
            default: state_next = CONV_IDLE;
        endcase
    end

    // Output decode for the datapath
    always_comb begin
        shift_en = (state == CONV_BUSY) && !start;
        finish   = shift_en && (iter == BCD_LAST_ITER);
    end

    // One adjust-and-shift step of {acc, bin_sr}
    always_comb begin
        acc_adj   = bcd_adjust(acc);
        acc_shift = {acc_adj[14:0], bin_sr[13]};
        bin_shift = {bin_sr[12:0], 1'b0};
    end

    // Datapath: shift register, iteration counter, result latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_sr <= '0;
            acc    <= '0;
            iter   <= '0;
            bcd    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bin_sr <= value;
                acc    <= '0;
                iter   <= '0;
            end else if (shift_en) begin
                bin_sr <= bin_shift;
                acc    <= acc_shift;
                iter   <= iter + 4'd1;
                if (finish) begin
                    bcd  <= acc_shift;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/meter_timer.sv
// ---------------------------------------------------------------------------
// meter_timer
// Parking-meter time keeper: second prescaler, remaining-time register with
// load/add/countdown priority, blink control and BCD image for the display.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : add/load request bus (meter_timer_if.slave)
//   t_meter   : remaining seconds, binary, 0..MAX_T
//   bcd       : four BCD digits of t_meter, thousands in [15:12]
//   bcd_valid : high when bcd matches the current t_meter
//   disp_on   : 1 = display lit this second, 0 = blanked
//   expired   : high while t_meter == 0
//   sec_tick  : one-cycle pulse at each second boundary
// ---------------------------------------------------------------------------
module meter_timer
    import meter_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int MAX_T    = MAX_T_DEF,
    parameter int LOW_T    = LOW_T_DEF
) (
    input  logic         clk,
    input  logic         rst,
    meter_timer_if.slave req,
    output logic [13:0]  t_meter,
    output logic [15:0]  bcd,
    output logic         bcd_valid,
    output logic         disp_on,
    output logic         expired,
    output logic         sec_tick
);

    localparam int          PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [13:0] MAX_V      = 14'(MAX_T);
    localparam logic [13:0] LOW_V      = 14'(LOW_T);

    logic [PW-1:0] presc;
    logic          phase;
    logic          phase_next;
    logic [13:0]   t_next;
    logic          t_changed;
    logic          disp_next;
    logic [14:0]   sum;
    logic [13:0]   sum_sat;
    logic          start_r;
    logic [15:0]   conv_bcd;
    logic          conv_done;

    assign sec_tick  = (presc == PRESC_LAST);
    assign expired   = (t_meter == 14'd0);
    assign t_changed = (t_next != t_meter);

    // Prescaler: wraps on the tick, restarts on load so the next
    // second is a full TICK_DIV cycles away
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (req.load_valid || sec_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Next time value, blink phase and display enable.
    // The add is done one bit wider so the clamp sees any overflow.
    // An add coinciding with a tick still consumes that second; the
    // smallest add is 60 so sum-1 cannot underflow.
    always_comb begin
        sum     = {1'b0, t_meter} + {1'b0, add_amount(add_sel_e'(req.add_sel))};
        sum_sat = (sum > {1'b0, MAX_V}) ? MAX_V : sum[13:0];

        t_next = t_meter;
        if (req.load_valid) begin
            t_next = req.load_sel ? LOAD_LONG : LOAD_SHORT;
        end else if (req.add_valid) begin
            t_next = sec_tick ? (sum_sat - 14'd1) : sum_sat;
        end else if (sec_tick && (t_meter != 14'd0)) begin
            t_next = t_meter - 14'd1;
        end

        // Phase is cleared when the meter first hits zero so the
        // expired display starts lit
        phase_next = phase;
        if (req.load_valid || ((t_next == 14'd0) && (t_meter != 14'd0))) begin
            phase_next = 1'b0;
        end else if (sec_tick && (t_meter == 14'd0)) begin
            phase_next = ~phase;
        end

        if (t_next >= LOW_V) begin
            disp_next = 1'b1;
        end else if (t_next != 14'd0) begin
            disp_next = ~t_next[0];
        end else begin
            disp_next = ~phase_next;
        end
    end

    // Time, phase and display registers update together so disp_on
    // always matches the t_meter it describes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_meter <= '0;
            phase   <= 1'b0;
            disp_on <= 1'b1;
        end else begin
            t_meter <= t_next;
            phase   <= phase_next;
            disp_on <= disp_next;
        end
    end

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start_r),
        .value (t_meter),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    // BCD validity: drop on any time change, start conversion next cycle,
    // accept a result only if no newer change is pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_r   <= 1'b0;
            bcd_valid <= 1'b1;
            bcd       <= '0;
        end else begin
            start_r <= t_changed;
            if (t_changed) begin
                bcd_valid <= 1'b0;
            end else if (conv_done && !start_r) begin
                bcd_valid <= 1'b1;
                bcd       <= conv_bcd;
            end
        end
    end

endmodule

// File: tb/tb_meter_timer.sv
// ---------------------------------------------------------------------------
// tb_meter_timer
// Directed self-checking bench for meter_timer. The prescaler is shortened
// to 20 cycles so a BCD conversion completes within every second.
// ---------------------------------------------------------------------------
module tb_meter_timer;

    localparam int TICK_DIV = 20;

    logic        clk;
    logic        rst;
    logic [13:0] t_meter;
    logic [15:0] bcd;
    logic        bcd_valid;
    logic        disp_on;
    logic        expired;
    logic        sec_tick;

    int total = 0;
    int bad   = 0;

    meter_timer_if bus ();

    meter_timer #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (bus),
        .t_meter   (t_meter),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .disp_on   (disp_on),
        .expired   (expired),
        .sec_tick  (sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_load(input logic sel);
        bus.load_sel   = sel;
        bus.load_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
    endtask

    task automatic apply_add(input logic [1:0] sel, input int n);
        bus.add_sel   = sel;
        bus.add_valid = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        bus.add_valid = 1'b0;
    endtask

    // Run up to the next second boundary and just past its clock edge
    task automatic wait_tick();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < TICK_DIV + 2; n++) begin
            @(negedge clk);
            if (sec_tick) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("tick_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Allow at most 16 clocks for bcd_valid, then check the digits
    task automatic wait_bcd(input string tag, input logic [15:0] exp);
        for (int n = 0; n < 16 && !bcd_valid; n++) begin
            @(posedge clk);
            #1;
        end
        check_output({tag, "_valid"}, {31'd0, bcd_valid}, 32'd1);
        check_output(tag, {16'd0, bcd}, {16'd0, exp});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        bus.add_valid  = 1'b0;
        bus.add_sel    = 2'd0;
        bus.load_valid = 1'b0;
        bus.load_sel   = 1'b0;
        rst = 1'b0;
        #2 rst = 1'b1;
        step(2);

        // Reset state
        check_output("rst_t", {18'd0, t_meter}, 32'd0);
        check_output("rst_expired", {31'd0, expired}, 32'd1);
        check_output("rst_disp", {31'd0, disp_on}, 32'd1);
        check_output("rst_bcd", {16'd0, bcd}, 32'd0);
        check_output("rst_bcd_valid", {31'd0, bcd_valid}, 32'd1);
        check_output("rst_tick", {31'd0, sec_tick}, 32'd0);
        rst = 1'b0;

        // Idle at zero: display blinks at 0.5 Hz, time holds
        wait_tick();
        check_output("idle1_disp", {31'd0, disp_on}, 32'd0);
        check_output("idle1_t", {18'd0, t_meter}, 32'd0);
        wait_tick();
        check_output("idle2_disp", {31'd0, disp_on}, 32'd1);
        wait_tick();
        check_output("idle3_disp", {31'd0, disp_on}, 32'd0);
        check_output("idle3_expired", {31'd0, expired}, 32'd1);

        // Load 185 and count down with 1 Hz low-time blink
        apply_load(1'b1);
        check_output("ld185_t", {18'd0, t_meter}, 32'd185);
        check_output("ld185_disp", {31'd0, disp_on}, 32'd0);
        check_output("ld185_expired", {31'd0, expired}, 32'd0);
        check_output("ld185_bcd_drop", {31'd0, bcd_valid}, 32'd0);
        wait_bcd("bcd185", 16'h0185);
        wait_tick();
        check_output("t184", {18'd0, t_meter}, 32'd184);
        check_output("t184_disp", {31'd0, disp_on}, 32'd1);
        wait_bcd("bcd184", 16'h0184);
        wait_tick();
        check_output("t183", {18'd0, t_meter}, 32'd183);
        check_output("t183_disp", {31'd0, disp_on}, 32'd0);
        wait_bcd("bcd183", 16'h0183);

        // Load 15 then add 300 while the first conversion is in flight
        apply_load(1'b0);
        check_output("ld15_t", {18'd0, t_meter}, 32'd15);
        check_output("ld15_disp", {31'd0, disp_on}, 32'd0);
        apply_add(2'd3, 1);
        check_output("t315", {18'd0, t_meter}, 32'd315);
        check_output("t315_disp", {31'd0, disp_on}, 32'd1);
        check_output("t315_bcd_drop", {31'd0, bcd_valid}, 32'd0);
        wait_bcd("bcd315", 16'h0315);
        wait_tick();
        check_output("t314", {18'd0, t_meter}, 32'd314);
        check_output("t314_disp", {31'd0, disp_on}, 32'd1);

        // Saturation: load 185, 19 adds of 300, one plain tick, then clamp
        apply_load(1'b1);
        apply_add(2'd3, 19);
        check_output("t5885", {18'd0, t_meter}, 32'd5885);
        step(1);
        check_output("t5884", {18'd0, t_meter}, 32'd5884);
        apply_add(2'd3, 13);
        check_output("t9784", {18'd0, t_meter}, 32'd9784);
        apply_add(2'd3, 1);
        check_output("clamp1", {18'd0, t_meter}, 32'd9999);
        apply_add(2'd3, 1);
        check_output("clamp2", {18'd0, t_meter}, 32'd9999);
        step(4);
        check_output("pre_tick", {31'd0, sec_tick}, 32'd1);
        apply_add(2'd3, 1);
        check_output("add_on_tick", {18'd0, t_meter}, 32'd9998);
        check_output("t9998_disp", {31'd0, disp_on}, 32'd1);

        // Load and add together: load wins, prescaler restarts
        apply_load(1'b0);
        apply_add(2'd3, 1);
        apply_add(2'd2, 1);
        check_output("t495", {18'd0, t_meter}, 32'd495);
        bus.add_sel    = 2'd3;
        bus.add_valid  = 1'b1;
        bus.load_sel   = 1'b0;
        bus.load_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.add_valid  = 1'b0;
        bus.load_valid = 1'b0;
        check_output("both_t", {18'd0, t_meter}, 32'd15);
        n = 0;
        while (t_meter == 14'd15 && n < TICK_DIV + 5) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("both_tick_period", n, TICK_DIV);
        check_output("both_t14", {18'd0, t_meter}, 32'd14);
        check_output("t14_disp", {31'd0, disp_on}, 32'd1);
        wait_bcd("bcd14", 16'h0014);

        // Count down to zero
        for (int i = 0; i < 12; i++) wait_tick();
        check_output("t2", {18'd0, t_meter}, 32'd2);
        check_output("t2_disp", {31'd0, disp_on}, 32'd1);
        wait_bcd("bcd2", 16'h0002);
        wait_tick();
        check_output("t1", {18'd0, t_meter}, 32'd1);
        check_output("t1_disp", {31'd0, disp_on}, 32'd0);
        check_output("t1_expired", {31'd0, expired}, 32'd0);
        wait_tick();
        check_output("t0", {18'd0, t_meter}, 32'd0);
        check_output("t0_expired", {31'd0, expired}, 32'd1);
        check_output("t0_disp_lit", {31'd0, disp_on}, 32'd1);
        wait_tick();
        check_output("t0_hold", {18'd0, t_meter}, 32'd0);
        check_output("t0_disp_off", {31'd0, disp_on}, 32'd0);
        wait_tick();
        check_output("t0_disp_on", {31'd0, disp_on}, 32'd1);
        wait_bcd("bcd0", 16'h0000);

        // Asynchronous reset mid-second and mid-conversion
        apply_load(1'b1);
        wait_bcd("bcd185b", 16'h0185);
        apply_load(1'b0);
        step(5);
        #3 rst = 1'b1;
        #1;
        check_output("arst_t", {18'd0, t_meter}, 32'd0);
        check_output("arst_bcd", {16'd0, bcd}, 32'd0);
        check_output("arst_bcd_valid", {31'd0, bcd_valid}, 32'd1);
        check_output("arst_disp", {31'd0, disp_on}, 32'd1);
        check_output("arst_expired", {31'd0, expired}, 32'd1);
        check_output("arst_tick", {31'd0, sec_tick}, 32'd0);
        step(3);
        rst = 1'b0;
        wait_tick();
        check_output("post_rst_t", {18'd0, t_meter}, 32'd0);
        check_output("post_rst_disp", {31'd0, disp_on}, 32'd0);
        wait_tick();
        check_output("post_rst_t2", {18'd0, t_meter}, 32'd0);
        check_output("post_rst_bcd_valid", {31'd0, bcd_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
